// File: rtl/nb_logic_pkg.sv
// ---------------------------------------------------------------------------
// nb_logic_pkg
// Shared constants for the pipelined bitwise logic unit: the op-select width
// and the eight op codes carried on in_op.
// ---------------------------------------------------------------------------
package nb_logic_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
   localparam logic [OP_W-1:0] OP_NAND = 3'b011;
   localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
   localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
   localparam logic [OP_W-1:0] OP_NOT  = 3'b110;  // NOT A, b ignored
   localparam logic [OP_W-1:0] OP_PASS = 3'b111;  // PASS A, b ignored

endpackage

// File: rtl/nb_logic_core.sv
// ---------------------------------------------------------------------------
// nb_logic_core
// Purely combinational bitwise logic function plus result flags.
//   a, b    : WIDTH-bit operands
//   op      : op select (nb_logic_pkg op codes)
//   result  : op(a, b), WIDTH bits, no carry or extension
//   zero    : result is all zeros
//   ones    : result is all ones
//   parity  : XOR-reduce of result (1 = odd number of ones)
// ---------------------------------------------------------------------------
module nb_logic_core
   import nb_logic_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ones,
   output logic             parity
);

   always_comb begin
      // NOTE: result gets a default before the case so every path assigns it
      // and no latch is inferred.
      result = a;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_XNOR: result = ~(a ^ b);
         OP_NOT:  result = ~a;
         OP_PASS: result = a;
         default: result = a;
      endcase
   end

   assign zero   = (result == '0);
   assign ones   = &result;
   assign parity = ^result;

endmodule

// File: rtl/nb_logic_pipe.sv
// ---------------------------------------------------------------------------
// nb_logic_pipe
// Two-stage pipelined bitwise logic unit with an accumulate mode and a
// valid/ready handshake with full backpressure.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : input handshake
//   in_a, in_b, in_op     : operands and op select
//   in_acc                : 1 = replace operand A with the accumulator
//   out_valid / out_ready : output handshake
//   out_result            : logic result
//   out_zero/ones/parity  : flags of out_result
//   acc_value             : current accumulator contents
// Stage 1 only registers the transaction; stage 2 computes and registers the
// result, its flags and the accumulator on the same edge.
// ---------------------------------------------------------------------------
module nb_logic_pipe
   import nb_logic_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OP_W-1:0]  in_op,
   input  logic             in_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_ones,
   output logic             out_parity,
   output logic [WIDTH-1:0] acc_value
);

   // Stage 1 registers
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;
   logic [OP_W-1:0]  s1_op_q,    s1_op_d;
   logic             s1_acc_q,   s1_acc_d;

   // Stage 2 (output) registers and accumulator
   logic             out_valid_q,  out_valid_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic             out_zero_q,   out_zero_d;
   logic             out_ones_q,   out_ones_d;
   logic             out_parity_q, out_parity_d;
   logic [WIDTH-1:0] acc_q,        acc_d;

   // Handshake
   logic s2_load;
   logic in_fire;

   // Core connections
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_result;
   logic             core_zero;
   logic             core_ones;
   logic             core_parity;

   // Stage 2 takes a new result when stage 1 holds one and the output
   // register is empty or being drained this cycle. in_ready passes
   // out_ready through combinationally; there is no skid buffer.
   assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s2_load;
   assign in_fire  = in_valid && in_ready;

   // The accumulator already holds the previous transaction's result when
   // this one reaches stage 2, so back-to-back accumulates chain unstalled.
   assign core_a = s1_acc_q ? acc_q : s1_a_q;

   nb_logic_core #(.WIDTH(WIDTH)) u_core (
      .a      (core_a),
      .b      (s1_b_q),
      .op     (s1_op_q),
      .result (core_result),
      .zero   (core_zero),
      .ones   (core_ones),
      .parity (core_parity)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s1_acc_d   = s1_acc_q;
      if (in_fire) begin
         // A simultaneous accept and move to stage 2 keeps s1_valid high.
         s1_valid_d = 1'b1;
         s1_a_d     = in_a;
         s1_b_d     = in_b;
         s1_op_d    = in_op;
         s1_acc_d   = in_acc;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_zero_d   = out_zero_q;
      out_ones_d   = out_ones_q;
      out_parity_d = out_parity_q;
      acc_d        = acc_q;
      if (s2_load) begin
         out_valid_d  = 1'b1;
         out_result_d = core_result;
         out_zero_d   = core_zero;
         out_ones_d   = core_ones;
         out_parity_d = core_parity;
         acc_d        = core_result;
      end else if (out_valid_q && out_ready) begin
         // Result and flags keep their last value; only valid drops.
         out_valid_d = 1'b0;
      end
   end

   // NOTE: every flop, data included, is reset because result, flags and
   // accumulator are visible outputs that must read zero during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_op_q      <= OP_AND;
         s1_acc_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_zero_q   <= 1'b0;
         out_ones_q   <= 1'b0;
         out_parity_q <= 1'b0;
         acc_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_op_q      <= s1_op_d;
         s1_acc_q     <= s1_acc_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_zero_q   <= out_zero_d;
         out_ones_q   <= out_ones_d;
         out_parity_q <= out_parity_d;
         acc_q        <= acc_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_zero   = out_zero_q;
   assign out_ones   = out_ones_q;
   assign out_parity = out_parity_q;
   assign acc_value  = acc_q;

endmodule
